// File: rtl/strip_pkg.sv
// Shared definitions for the rectangle strip allocator: geometry, FSM states, height-to-ROM-address map.
// Latency: n/a (package).
// Backpressure: n/a (package).
package strip_pkg;

  localparam int NUM_STRIPS  = 13;
  localparam int STRIP_WIDTH = 128;
  localparam int FILL_W      = 8;
  localparam int HEIGHT_MIN  = 4;
  localparam int HEIGHT_MAX  = 16;

  localparam logic [3:0] ID_INVALID = 4'hD;

  // Sized copies for direct comparison against narrow datapath signals.
  localparam logic [3:0]      NUM_STRIPS_ID = 4'(NUM_STRIPS);
  localparam logic [FILL_W:0] STRIP_WIDTH_W = (FILL_W + 1)'(STRIP_WIDTH);
  localparam logic [4:0]      HEIGHT_MIN_H  = 5'(HEIGHT_MIN);
  localparam logic [4:0]      HEIGHT_MAX_H  = 5'(HEIGHT_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    CHECK  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Heights 4..12 map linearly to 0..8; 13..16 share the last ROM row.
  // Only meaningful for heights already known to be in range.
  function automatic logic [3:0] height_to_addr(input logic [4:0] h);
    logic [4:0] d;
    d = h - HEIGHT_MIN_H;
    if (h >= 5'd13) return 4'd9;
    return d[3:0];
  endfunction

endpackage

// File: rtl/strip_fill_table.sv
// Per-strip fill counters with one combinational read port and one read-modify-write add port.
// Latency: read is combinational; add and clear take effect at the next clock edge.
// Backpressure: none; the caller guarantees add and clear are never needed together.
// Ports: clk/rst (async, active-high); clr_i zeroes every counter; rd_idx_i/rd_fill_o read;
//        add_en_i/add_idx_i/add_val_i add add_val_i to the addressed counter.
module strip_fill_table
  import strip_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [3:0]        rd_idx_i,
  output logic [FILL_W-1:0] rd_fill_o,
  input  logic              add_en_i,
  input  logic [3:0]        add_idx_i,
  input  logic [FILL_W-1:0] add_val_i
);

  logic [FILL_W-1:0] fill_q [NUM_STRIPS];

  // Out-of-range indices (invalid candidates) read as empty; the caller masks them anyway.
  assign rd_fill_o = (rd_idx_i < NUM_STRIPS_ID) ? fill_q[rd_idx_i] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STRIPS; i++) fill_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < NUM_STRIPS; i++) fill_q[i] <= '0;
    end else if (add_en_i && (add_idx_i < NUM_STRIPS_ID)) begin
      fill_q[add_idx_i] <= fill_q[add_idx_i] + add_val_i;
    end
  end

endmodule

// File: rtl/strip_allocator.sv
// Allocates a rectangle into the first of up to three ROM-supplied candidate strips with room left.
// Latency: accept to resp_valid is 1 cycle for a rejected request, 3/4/5 cycles for hit on id1/id2/id3-or-fail.
// Backpressure: one request in flight; req_ready is low until the held response is taken with resp_ready.
// Ports: req_* rectangle request (valid/ready); clear_all empties the fill table when idle;
//        rom_addr out / rom_id1..3 in talk to the registered strip-ID ROM; resp_* result (valid/ready).
// Optional: define STRIP_ALLOC_STATS_EN to add saturating stat_alloc/stat_fail counters.
module strip_allocator
  import strip_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_height,
  input  logic [FILL_W-1:0] req_width,
  input  logic              clear_all,
  output logic [3:0]        rom_addr,
  input  logic [3:0]        rom_id1,
  input  logic [3:0]        rom_id2,
  input  logic [3:0]        rom_id3,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [3:0]        resp_strip,
  output logic [FILL_W-1:0] resp_xoff,
  output logic              resp_fail
`ifdef STRIP_ALLOC_STATS_EN
  ,
  output logic [15:0]       stat_alloc,
  output logic [15:0]       stat_fail
`endif
);

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [FILL_W-1:0] width_q, width_d;
  logic [3:0]        rom_addr_q, rom_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [3:0]        resp_strip_q, resp_strip_d;
  logic [FILL_W-1:0] resp_xoff_q, resp_xoff_d;
  logic              resp_fail_q, resp_fail_d;

  logic              clr_en;
  logic              req_bad;
  logic [3:0]        cand_id;
  logic              cand_vld;
  logic [FILL_W-1:0] cand_fill;
  logic [FILL_W:0]   cand_sum;
  logic              hit;
  logic              add_en;

  assign req_ready  = (state_q == IDLE);
  assign clr_en     = clear_all && (state_q == IDLE);
  assign rom_addr   = rom_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_strip = resp_strip_q;
  assign resp_xoff  = resp_xoff_q;
  assign resp_fail  = resp_fail_q;

  assign req_bad = (req_height < HEIGHT_MIN_H) || (req_height > HEIGHT_MAX_H) ||
                   (req_width == '0) || ({1'b0, req_width} > STRIP_WIDTH_W);

  always_comb begin
    case (k_q)
      2'd0:    cand_id = rom_id1;
      2'd1:    cand_id = rom_id2;
      default: cand_id = rom_id3;
    endcase
  end

  assign cand_vld = (cand_id < NUM_STRIPS_ID);
  // One extra bit so a nearly full strip plus a wide rectangle cannot wrap and look like a fit.
  assign cand_sum = {1'b0, cand_fill} + {1'b0, width_q};
  assign hit      = cand_vld && (cand_sum <= STRIP_WIDTH_W);

  strip_fill_table u_fill (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_en),
    .rd_idx_i  (cand_id),
    .rd_fill_o (cand_fill),
    .add_en_i  (add_en),
    .add_idx_i (cand_id),
    .add_val_i (width_q)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    width_d      = width_q;
    rom_addr_d   = rom_addr_q;
    resp_valid_d = resp_valid_q;
    resp_strip_d = resp_strip_q;
    resp_xoff_d  = resp_xoff_q;
    resp_fail_d  = resp_fail_q;
    add_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          width_d = req_width;
          if (req_bad) begin
            resp_valid_d = 1'b1;
            resp_fail_d  = 1'b1;
            resp_strip_d = ID_INVALID;
            resp_xoff_d  = '0;
            state_d      = RESP;
          end else begin
            rom_addr_d = height_to_addr(req_height);
            state_d    = LOOKUP;
          end
        end
      end
      // The ROM registers rom_addr on this edge; its candidates are usable in CHECK.
      LOOKUP: begin
        k_d     = 2'd0;
        state_d = CHECK;
      end
      CHECK: begin
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_fail_d  = 1'b0;
          resp_strip_d = cand_id;
          resp_xoff_d  = cand_fill;
          add_en       = 1'b1;
          state_d      = RESP;
        end else if (k_q == 2'd2) begin
          resp_valid_d = 1'b1;
          resp_fail_d  = 1'b1;
          resp_strip_d = ID_INVALID;
          resp_xoff_d  = '0;
          state_d      = RESP;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      width_q      <= '0;
      rom_addr_q   <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_strip_q <= ID_INVALID;
      resp_xoff_q  <= '0;
      resp_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      width_q      <= width_d;
      rom_addr_q   <= rom_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_strip_q <= resp_strip_d;
      resp_xoff_q  <= resp_xoff_d;
      resp_fail_q  <= resp_fail_d;
    end
  end

`ifdef STRIP_ALLOC_STATS_EN
  logic        resp_hs;
  logic [15:0] stat_alloc_q, stat_alloc_d;
  logic [15:0] stat_fail_q, stat_fail_d;

  assign resp_hs    = resp_valid_q && resp_ready;
  assign stat_alloc = stat_alloc_q;
  assign stat_fail  = stat_fail_q;

  always_comb begin
    stat_alloc_d = stat_alloc_q;
    stat_fail_d  = stat_fail_q;
    if (clr_en) begin
      stat_alloc_d = '0;
      stat_fail_d  = '0;
    end else if (resp_hs) begin
      if (resp_fail_q) begin
        if (stat_fail_q != 16'hFFFF) stat_fail_d = stat_fail_q + 16'd1;
      end else begin
        if (stat_alloc_q != 16'hFFFF) stat_alloc_d = stat_alloc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_alloc_q <= '0;
      stat_fail_q  <= '0;
    end else begin
      stat_alloc_q <= stat_alloc_d;
      stat_fail_q  <= stat_fail_d;
    end
  end
`endif

endmodule

// File: tb/tb_strip_allocator.sv
// Bench for strip_allocator: registered ROM model, reference allocator, scoreboard queue and monitor.
// Latency: n/a.
// Backpressure: resp_ready is held low for a directed window, then toggled randomly.
module tb_strip_allocator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_height = '0;
  logic [7:0] req_width = '0;
  logic       clear_all = 1'b0;
  logic [3:0] rom_addr;
  logic [3:0] rom_id1, rom_id2, rom_id3;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [3:0] resp_strip;
  logic [7:0] resp_xoff;
  logic       resp_fail;

  strip_allocator dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_height (req_height),
    .req_width  (req_width),
    .clear_all  (clear_all),
    .rom_addr   (rom_addr),
    .rom_id1    (rom_id1),
    .rom_id2    (rom_id2),
    .rom_id3    (rom_id3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_strip (resp_strip),
    .resp_xoff  (resp_xoff),
    .resp_fail  (resp_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int strip;
    int xoff;
    int fail;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   rom_tbl[10][3];
  int   fill[13];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_done = 0;
  bit   in_resp = 0;
  bit   rand_rdy = 0;
  int   cap_strip, cap_xoff, cap_fail;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Registered strip-ID ROM: candidates appear one cycle after rom_addr is sampled.
  always @(posedge clk) begin
    if (rom_addr < 4'd10) begin
      rom_id1 <= 4'(rom_tbl[rom_addr][0]);
      rom_id2 <= 4'(rom_tbl[rom_addr][1]);
      rom_id3 <= 4'(rom_tbl[rom_addr][2]);
    end else begin
      rom_id1 <= 4'hF;
      rom_id2 <= 4'hF;
      rom_id3 <= 4'hF;
    end
  end

  // Reference allocator: first listed strip with room wins; rejected requests never reach the ROM.
  task automatic model(input int h, input int w, input bit clr);
    exp_t e;
    int   addr;
    bit   found;
    if (clr) foreach (fill[i]) fill[i] = 0;
    e.strip = 13; e.xoff = 0; e.fail = 1; e.lat = 5;
    if (h < 4 || h > 16 || w == 0 || w > 128) begin
      e.lat = 1;
    end else begin
      addr  = (h <= 12) ? h - 4 : 9;
      found = 0;
      for (int j = 0; j < 3; j++) begin
        int id;
        id = rom_tbl[addr][j];
        if (!found && id < 13 && fill[id] + w <= 128) begin
          found   = 1;
          e.strip = id;
          e.xoff  = fill[id];
          e.fail  = 0;
          e.lat   = 3 + j;
          fill[id] += w;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per response and checks it stays frozen until taken.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_resp = 0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (resp_valid) begin
        if (!in_resp) begin
          in_resp   = 1;
          cap_strip = resp_strip;
          cap_xoff  = resp_xoff;
          cap_fail  = resp_fail;
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_strip", resp_strip, e.strip);
            chk("resp_xoff", resp_xoff, e.xoff);
            chk("resp_fail", resp_fail, e.fail);
            chk("latency", cyc - acc_cyc, e.lat);
          end
        end else begin
          chk("hold_strip", resp_strip, cap_strip);
          chk("hold_xoff", resp_xoff, cap_xoff);
          chk("hold_fail", resp_fail, cap_fail);
        end
        chk("req_ready_in_resp", req_ready, 0);
        if (resp_ready) begin
          in_resp = 0;
          n_done++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      resp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send(input int h, input int w, input bit clr, input bit expect_resp);
    int n;
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_height = 5'(h);
    req_width  = 8'(w);
    clear_all  = clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    if (expect_resp) model(h, w, clr);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clear_all = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (n_done <= start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n_done <= start) chk("resp_timeout", 0, 1);
  endtask

  task automatic req(input int h, input int w, input bit clr);
    int d0;
    d0 = n_done;
    send(h, w, clr, 1);
    wait_done(d0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra, d0, n;
    for (int a = 0; a < 10; a++) begin
      rom_tbl[a][0] = (a * 5 + 3) % 16;
      rom_tbl[a][1] = (a * 7 + 1) % 16;
      rom_tbl[a][2] = (a * 3 + 11) % 16;
    end
    rom_tbl[4] = '{0, 1, 2};
    rom_tbl[0] = '{9, 7, 13};
    foreach (fill[i]) fill[i] = 0;

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_strip", resp_strip, 13);
    chk("rst_resp_xoff", resp_xoff, 0);
    chk("rst_resp_fail", resp_fail, 0);
    chk("rst_rom_addr", rom_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1);

    // Priority walk through candidates {0,1,2}, including an exact fit.
    req(8, 100, 0);
    req(8, 100, 0);
    req(8, 28, 0);
    // Candidates {9,7,D}: full-width rectangles exhaust both real strips, then fail.
    req(4, 128, 0);
    req(4, 128, 0);
    req(4, 128, 0);

    // Rejected requests never touch the ROM address.
    ra = rom_addr;
    req(3, 10, 0);
    req(17, 10, 0);
    req(8, 0, 0);
    req(8, 129, 0);
    chk("bad_rom_addr", rom_addr, ra);

    // Backpressure with a clear_all pulse that must be ignored outside IDLE.
    resp_ready = 1'b0;
    d0 = n_done;
    send(8, 10, 0, 1);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) chk("bp_resp_timeout", 0, 1);
    @(posedge clk);
    #1 clear_all = 1'b1;
    @(posedge clk);
    #1 clear_all = 1'b0;
    repeat (2) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_done(d0);
    @(negedge clk);
    chk("req_ready_after_hs", req_ready, 1);
    req(8, 18, 0);

    // Reset in CHECK drops the request; then clear_all empties the table.
    send(8, 50, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    foreach (fill[i]) fill[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_resp_after_rst", resp_valid, 0);
    req(8, 100, 0);
    req(4, 60, 0);
    @(posedge clk);
    #1 clear_all = 1'b1;
    @(posedge clk);
    #1 clear_all = 1'b0;
    foreach (fill[i]) fill[i] = 0;
    req(8, 100, 0);
    req(8, 100, 0);
    // Clear and request in the same cycle: request sees the cleared table.
    req(8, 100, 1);

    // Randomized traffic with random response backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 200; i++) begin
      int h, w, r;
      bit clr;
      h = $urandom_range(2, 18);
      r = $urandom_range(0, 9);
      if (r == 0)      w = 0;
      else if (r == 1) w = $urandom_range(129, 255);
      else if (r == 2) w = 128;
      else             w = $urandom_range(1, 64);
      clr = ($urandom_range(0, 15) == 0);
      req(h, w, clr);
    end
    rand_rdy = 0;
    repeat (3) @(posedge clk);
    #1 resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
